// File: rtl/countdown_sequencer.sv
// countdown_sequencer: load-and-count-down iteration sequencer
// for the multdiv shift/add datapath.
//
// Ports:
//   clock       rising-edge clock
//   clr         synchronous active-high reset, beats all inputs
//   start       begin a sequence (taken only when ready)
//   use_default 1: load DEFAULT_LOAD, 0: load load_val
//   load_val    explicit iteration budget
//   en          advance enable (0 = datapath stall)
//   abort       cancel a running sequence, no done
//   count       remaining iterations (registered)
//   busy        sequence running
//   step        datapath performs one iteration this cycle
//   last        current iteration is the final one
//   done        one-cycle pulse after the final step
//   ready       idle, start will be accepted
module countdown_sequencer #(
  parameter int WIDTH        = 6,
  parameter int DEFAULT_LOAD = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             step,
  output logic             last,
  output logic             done,
  output logic             ready
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] DEF_V =
    WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] sel_v;

  assign sel_v = use_default ? DEF_V : load_val;

  always_ff @(posedge clock) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_v != '0) begin
            count_d = sel_v;
            state_d = RUN;
          end else begin
            // zero budget: straight to done,
            // no step is ever issued
            count_d = '0;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (en) begin
          if (count_q == ONE) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      DONE: begin
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign count = count_q;
  assign step  = busy & en & ~abort;
  assign last  = busy & (count_q == ONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed bench for
// countdown_sequencer.
module tb_countdown_sequencer;

  logic       clock;
  logic       clr;
  logic       start;
  logic       use_default;
  logic [5:0] load_val;
  logic       en;
  logic       abort;
  logic [5:0] count;
  logic       busy;
  logic       step;
  logic       last;
  logic       done;
  logic       ready;

  int nvec  = 0;
  int nfail = 0;

  countdown_sequencer #(
    .WIDTH(6),
    .DEFAULT_LOAD(32)
  ) dut (
    .clock(clock),
    .clr(clr),
    .start(start),
    .use_default(use_default),
    .load_val(load_val),
    .en(en),
    .abort(abort),
    .count(count),
    .busy(busy),
    .step(step),
    .last(last),
    .done(done),
    .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: no summary reached");
    $fatal(1, "timeout");
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input int c,
                         input bit b,
                         input bit s,
                         input bit l,
                         input bit d,
                         input bit r);
    #1;
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".step"},  32'(step),  32'(s));
    chk({tag, ".last"},  32'(last),  32'(l));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".ready"}, 32'(ready), 32'(r));
  endtask

  initial begin
    clr = 1'b1;
    start = 1'b0;
    use_default = 1'b0;
    load_val = '0;
    en = 1'b1;
    abort = 1'b0;
    nxt();
    chk_out("rst", 0, 0, 0, 0, 0, 1);
    clr = 1'b0;
    nxt();

    // default budget of 32, en held high
    start = 1'b1;
    use_default = 1'b1;
    nxt();
    start = 1'b0;
    use_default = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk_out("def", 33 - k, 1, 1,
              k == 32, 0, 0);
      nxt();
    end
    chk_out("def_done", 0, 0, 0, 0, 1, 0);
    nxt();
    chk_out("def_rdy", 0, 0, 0, 0, 0, 1);

    // budget 5, stall in cycles 2-3
    load_val = 6'd5;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("st1", 5, 1, 1, 0, 0, 0);
    nxt();
    en = 1'b0;
    chk_out("st2", 4, 1, 0, 0, 0, 0);
    nxt();
    chk_out("st3", 4, 1, 0, 0, 0, 0);
    nxt();
    en = 1'b1;
    chk_out("st4", 4, 1, 1, 0, 0, 0);
    nxt();
    chk_out("st5", 3, 1, 1, 0, 0, 0);
    nxt();
    chk_out("st6", 2, 1, 1, 0, 0, 0);
    nxt();
    chk_out("st7", 1, 1, 1, 1, 0, 0);
    nxt();
    chk_out("st8", 0, 0, 0, 0, 1, 0);
    nxt();
    chk_out("st9", 0, 0, 0, 0, 0, 1);

    // zero budget
    load_val = 6'd0;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("z1", 0, 0, 0, 0, 1, 0);
    nxt();
    chk_out("z2", 0, 0, 0, 0, 0, 1);

    // budget 10, abort in cycle 4
    load_val = 6'd10;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("ab1", 10, 1, 1, 0, 0, 0);
    nxt();
    nxt();
    nxt();
    abort = 1'b1;
    chk_out("ab4", 7, 1, 0, 0, 0, 0);
    nxt();
    abort = 1'b0;
    chk_out("ab5", 0, 0, 0, 0, 0, 1);
    load_val = 6'd2;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("ab6", 2, 1, 1, 0, 0, 0);
    nxt();
    chk_out("ab7", 1, 1, 1, 1, 0, 0);
    nxt();
    chk_out("ab8", 0, 0, 0, 0, 1, 0);
    nxt();

    // start held high through a budget-3 run
    load_val = 6'd3;
    start = 1'b1;
    nxt();
    chk_out("hd1", 3, 1, 1, 0, 0, 0);
    nxt();
    chk_out("hd2", 2, 1, 1, 0, 0, 0);
    nxt();
    chk_out("hd3", 1, 1, 1, 1, 0, 0);
    nxt();
    chk_out("hd4", 0, 0, 0, 0, 1, 0);
    nxt();
    chk_out("hd5", 0, 0, 0, 0, 0, 1);
    nxt();
    start = 1'b0;
    chk_out("hd6", 3, 1, 1, 0, 0, 0);
    nxt();
    nxt();
    nxt();
    chk_out("hd9", 0, 0, 0, 0, 1, 0);
    nxt();

    // budget 63, clr in cycle 6
    load_val = 6'd63;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("cl1", 63, 1, 1, 0, 0, 0);
    for (int k = 2; k <= 6; k++) nxt();
    clr = 1'b1;
    chk_out("cl6", 58, 1, 1, 0, 0, 0);
    nxt();
    clr = 1'b0;
    chk_out("cl7", 0, 0, 0, 0, 0, 1);

    // clr coincident with start
    clr = 1'b1;
    start = 1'b1;
    nxt();
    clr = 1'b0;
    start = 1'b0;
    chk_out("cs", 0, 0, 0, 0, 0, 1);

    // budget 1, abort on the final step
    load_val = 6'd1;
    start = 1'b1;
    nxt();
    start = 1'b0;
    chk_out("fa0", 1, 1, 1, 1, 0, 0);
    abort = 1'b1;
    chk_out("fa1", 1, 1, 0, 1, 0, 0);
    nxt();
    abort = 1'b0;
    chk_out("fa2", 0, 0, 0, 0, 0, 1);
    nxt();
    chk_out("fa3", 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
